// File: rtl/smt_pkg.sv
// rtl/smt_pkg.sv - shared types and helpers for the SMT request queue
package smt_pkg;

  typedef logic tid_t;

  localparam tid_t TID_T0 = 1'b0;
  localparam tid_t TID_T1 = 1'b1;

  // Pointer width: index bits plus one wrap bit to tell full from empty
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/smt_req_fifo.sv
// rtl/smt_req_fifo.sv - per-thread request FIFO with wrap-bit pointers
module smt_req_fifo
  import smt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Advance write/read pointers; reset discards everything queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign count = wptr - rptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/smt_req_queue.sv
// rtl/smt_req_queue.sv - two-thread SMT requester queue and issue register (optional SMT_REQ_PERF_EN wait counters)
module smt_req_queue
  import smt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t0_push_valid,
  output logic              t0_push_ready,
  input  logic [DATA_W-1:0] t0_push_data,
  input  logic              t1_push_valid,
  output logic              t1_push_ready,
  input  logic [DATA_W-1:0] t1_push_data,
  output logic              t0_req,
  output logic              t1_req,
  input  logic              grant_t0,
  input  logic              grant_t1,
  output logic              issue_valid,
  output logic              issue_tid,
  output logic [DATA_W-1:0] issue_data,
  input  logic              issue_ready,
  output logic              proto_err
`ifdef SMT_REQ_PERF_EN
  ,
  output logic [15:0]       t0_wait_cnt,
  output logic [15:0]       t1_wait_cnt
`endif
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] t0_head, t1_head;
  logic [PW-1:0]     t0_count, t1_count;
  logic              t0_full, t1_full;
  logic              t0_empty, t1_empty;
  logic              t0_push, t1_push;
  logic              t0_pop, t1_pop;
  logic              slot_free;
  logic              both_grants;
  logic              bad_grant;
  logic              unused_full;

  assign t0_push_ready = (t0_count < PW'(DEPTH));
  assign t1_push_ready = (t1_count < PW'(DEPTH));
  assign t0_push       = t0_push_valid && t0_push_ready;
  assign t1_push       = t1_push_valid && t1_push_ready;

  // The issue register can take a new entry when empty or being drained now
  assign slot_free = !issue_valid || issue_ready;

  assign t0_req = !t0_empty && slot_free;
  assign t1_req = !t1_empty && slot_free;

  // A double grant is never honoured, even if both threads were requesting
  assign both_grants = grant_t0 && grant_t1;
  assign t0_pop      = grant_t0 && t0_req && !both_grants;
  assign t1_pop      = grant_t1 && t1_req && !both_grants;
  assign bad_grant   = both_grants || (grant_t0 && !t0_req) || (grant_t1 && !t1_req);

  // Full flags are implied by the count-based push_ready and are not needed here
  assign unused_full = t0_full ^ t1_full;

  smt_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_t0 (
    .clk       (clk),
    .rst       (rst),
    .push      (t0_push),
    .push_data (t0_push_data),
    .pop       (t0_pop),
    .head      (t0_head),
    .count     (t0_count),
    .full      (t0_full),
    .empty     (t0_empty)
  );

  smt_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_t1 (
    .clk       (clk),
    .rst       (rst),
    .push      (t1_push),
    .push_data (t1_push_data),
    .pop       (t1_pop),
    .head      (t1_head),
    .count     (t1_count),
    .full      (t1_full),
    .empty     (t1_empty)
  );

  // Issue register: load the granted head, otherwise retire on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_tid   <= TID_T0;
      issue_data  <= '0;
    end else if (t0_pop) begin
      issue_valid <= 1'b1;
      issue_tid   <= TID_T0;
      issue_data  <= t0_head;
    end else if (t1_pop) begin
      issue_valid <= 1'b1;
      issue_tid   <= TID_T1;
      issue_data  <= t1_head;
    end else if (issue_valid && issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (bad_grant) begin
      proto_err <= 1'b1;
    end
  end

`ifdef SMT_REQ_PERF_EN
  // Saturating count of cycles each thread requested without a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0_wait_cnt <= '0;
      t1_wait_cnt <= '0;
    end else begin
      if (t0_req && !grant_t0 && (t0_wait_cnt != 16'hFFFF)) t0_wait_cnt <= t0_wait_cnt + 16'd1;
      if (t1_req && !grant_t1 && (t1_wait_cnt != 16'hFFFF)) t1_wait_cnt <= t1_wait_cnt + 16'd1;
    end
  end
`else
  // Wait counters are not built in this configuration
`endif

endmodule

// File: tb/tb_smt_req_queue.sv
// tb/tb_smt_req_queue.sv - directed self-checking bench for smt_req_queue
module tb_smt_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        t0_push_valid, t1_push_valid;
  logic        t0_push_ready, t1_push_ready;
  logic [63:0] t0_push_data, t1_push_data;
  logic        t0_req, t1_req;
  logic        grant_t0, grant_t1;
  logic        issue_valid, issue_tid;
  logic [63:0] issue_data;
  logic        issue_ready;
  logic        proto_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  smt_req_queue #(.DATA_W(64), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .t0_push_valid (t0_push_valid),
    .t0_push_ready (t0_push_ready),
    .t0_push_data  (t0_push_data),
    .t1_push_valid (t1_push_valid),
    .t1_push_ready (t1_push_ready),
    .t1_push_data  (t1_push_data),
    .t0_req        (t0_req),
    .t1_req        (t1_req),
    .grant_t0      (grant_t0),
    .grant_t1      (grant_t1),
    .issue_valid   (issue_valid),
    .issue_tid     (issue_tid),
    .issue_data    (issue_data),
    .issue_ready   (issue_ready),
    .proto_err     (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_t0(input logic [63:0] d);
    t0_push_valid = 1'b1;
    t0_push_data  = d;
    step();
    t0_push_valid = 1'b0;
  endtask

  task automatic push_t1(input logic [63:0] d);
    t1_push_valid = 1'b1;
    t1_push_data  = d;
    step();
    t1_push_valid = 1'b0;
  endtask

  task automatic push_both(input logic [63:0] d0, input logic [63:0] d1);
    t0_push_valid = 1'b1;
    t0_push_data  = d0;
    t1_push_valid = 1'b1;
    t1_push_data  = d1;
    step();
    t0_push_valid = 1'b0;
    t1_push_valid = 1'b0;
  endtask

  task automatic grant_one(input logic tid, input logic [63:0] exp);
    issue_ready = 1'b1;
    #1;
    check(tid ? "t1_req_before_grant" : "t0_req_before_grant", tid ? t1_req : t0_req, 1);
    if (tid) grant_t1 = 1'b1;
    else     grant_t0 = 1'b1;
    step();
    grant_t0 = 1'b0;
    grant_t1 = 1'b0;
    check("issue_valid_after_grant", issue_valid, 1);
    check("issue_tid_after_grant", issue_tid, tid);
    check("issue_data_after_grant", issue_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    t0_push_valid = 1'b0; t1_push_valid = 1'b0;
    t0_push_data = '0; t1_push_data = '0;
    grant_t0 = 1'b0; grant_t1 = 1'b0;
    issue_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_tid", issue_tid, 0);
    check("rst_issue_data", issue_data, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_t0_req", t0_req, 0);
    check("rst_t0_push_ready", t0_push_ready, 1);
    check("rst_t1_push_ready", t1_push_ready, 1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push_t0(64'h10 + 64'(i));
    check("mid_t0_count", dut.u_fifo_t0.count, 3);
    check("mid_t0_req", t0_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_count", dut.u_fifo_t0.count, 0);
    check("mid_rst_t0_req", t0_req, 0);
    check("mid_rst_issue_valid", issue_valid, 0);
    check("mid_rst_proto_err", proto_err, 0);

    // Single-thread flow
    for (int i = 0; i < 4; i++) push_t0(64'hA0 + 64'(i));
    check("t0_full_push_ready", t0_push_ready, 0);
    for (int i = 0; i < 4; i++) grant_one(1'b0, 64'hA0 + 64'(i));
    check("t0_drained_req", t0_req, 0);
    step();
    check("single_idle_valid", issue_valid, 0);

    // Interleave both threads
    for (int i = 0; i < 4; i++) push_both(64'hB0 + 64'(i), 64'hC0 + 64'(i));
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) grant_one(1'b1, 64'hC0 + 64'(i / 2));
      else            grant_one(1'b0, 64'hB0 + 64'(i / 2));
    end
    step();
    check("interleave_idle_valid", issue_valid, 0);

    // Backpressure
    push_both(64'hD0, 64'hE0);
    push_both(64'hD1, 64'hE1);
    grant_one(1'b0, 64'hD0);
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_t0_req", t0_req, 0);
      check("bp_t1_req", t1_req, 0);
      step();
      check("bp_issue_valid", issue_valid, 1);
      check("bp_issue_data", issue_data, 64'hD0);
      check("bp_issue_tid", issue_tid, 0);
    end
    check("bp_t0_count", dut.u_fifo_t0.count, 1);
    check("bp_t1_count", dut.u_fifo_t1.count, 2);
    grant_one(1'b1, 64'hE0);
    grant_one(1'b0, 64'hD1);
    grant_one(1'b1, 64'hE1);
    step();
    check("bp_idle_valid", issue_valid, 0);

    // Full FIFO, refused push during pop, and pointer wrap
    for (int i = 0; i < 4; i++) push_t1(64'hF0 + 64'(i));
    check("t1_full_push_ready", t1_push_ready, 0);
    t1_push_valid = 1'b1;
    t1_push_data  = 64'hFF;
    grant_one(1'b1, 64'hF0);
    t1_push_valid = 1'b0;
    check("refused_push_count", dut.u_fifo_t1.count, 3);
    check("refused_push_ready", t1_push_ready, 1);
    t1_push_valid = 1'b1;
    t1_push_data  = 64'hF4;
    grant_one(1'b1, 64'hF1);
    t1_push_valid = 1'b0;
    check("push_pop_count", dut.u_fifo_t1.count, 3);
    grant_one(1'b1, 64'hF2);
    grant_one(1'b1, 64'hF3);
    grant_one(1'b1, 64'hF4);
    for (int i = 0; i < 4; i++) push_t1(64'h60 + 64'(i));
    for (int i = 0; i < 4; i++) grant_one(1'b1, 64'h60 + 64'(i));
    for (int i = 4; i < 6; i++) push_t1(64'h60 + 64'(i));
    for (int i = 4; i < 6; i++) grant_one(1'b1, 64'h60 + 64'(i));
    step();
    check("wrap_idle_valid", issue_valid, 0);

    // Grant to an empty thread
    grant_t1 = 1'b1;
    step();
    grant_t1 = 1'b0;
    check("err_empty_issue_valid", issue_valid, 0);
    check("err_empty_proto_err", proto_err, 1);
    repeat (3) step();
    check("err_sticky", proto_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("err_cleared_by_rst", proto_err, 0);

    // Both grants together
    push_both(64'h70, 64'h71);
    issue_ready = 1'b1;
    grant_t0 = 1'b1;
    grant_t1 = 1'b1;
    step();
    grant_t0 = 1'b0;
    grant_t1 = 1'b0;
    check("dual_issue_valid", issue_valid, 0);
    check("dual_proto_err", proto_err, 1);
    check("dual_t0_count", dut.u_fifo_t0.count, 1);
    check("dual_t1_count", dut.u_fifo_t1.count, 1);
    grant_one(1'b0, 64'h70);
    grant_one(1'b1, 64'h71);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
